// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: data width, the NOP filler word
// and the fetch state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection (redirect / +4 / hold) and redirect target
// alignment check. Optional feature macro: FETCH_MISALIGN_CHECK_EN.
module fetch_pc_gen (
  input  logic [riscv_pkg::XLEN-1:0] pc,
  input  logic                       redirect_valid,
  input  logic [riscv_pkg::XLEN-1:0] redirect_pc,
  input  logic                       advance,
  output logic [riscv_pkg::XLEN-1:0] next_pc,
  output logic                       misaligned
);

  import riscv_pkg::*;

  logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
  // The raw target is kept so the faulting address stays visible on imem_addr.
  assign target     = redirect_pc;
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign target     = redirect_pc & ~XLEN'(3);
  assign misaligned = 1'b0;
`endif

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = target;
    end else if (advance) begin
      next_pc = pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction memory address, and a
// valid/ready output slot toward decode. Optional macro: FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [31:0]     out_instr,
  output logic            fault
);

  import riscv_pkg::*;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            misaligned;
  logic            load;
  logic            valid_next;

  fetch_pc_gen u_pc_gen (
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (load),
    .next_pc        (pc_next),
    .misaligned     (misaligned)
  );

  // A redirect always wins over a fetch, so no load happens in its cycle.
  assign load = (state == RUN) && !redirect_valid && (!out_valid || out_ready);

  always_comb begin
    state_next = state;
    valid_next = out_valid;
    if (redirect_valid) begin
      state_next = misaligned ? FAULT : RUN;
      valid_next = 1'b0;
    end else begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = RUN;
        FAULT:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
      if (load) begin
        valid_next = 1'b1;
      end else if (out_ready) begin
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= NOP_INSTR;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      out_valid <= valid_next;
      if (load) begin
        out_pc    <= pc;
        out_instr <= imem_instr;
      end
    end
  end

  assign imem_addr    = pc;
  assign out_pc_plus4 = out_pc + XLEN'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fault = (state == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset/run, async reset, redirect, stall,
// address wrap and misaligned redirect, with a combinational memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic        fault;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_instr      (out_instr),
    .fault          (fault)
  );

  // Memory content: upper half is the inverted low address half.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_plus4"}, out_pc_plus4, pc + 32'd4);
    chk({tag, "_instr"}, out_instr, mem_word(pc));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_plus4"}, out_pc_plus4, 32'd4);
    chk({tag, "_instr"}, out_instr, 32'h0000_0013);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #2 rst_n = 1'b0;
    #10;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Reset and run: edge 1 still empty, edges 2..5 carry 0,4,8,12
    step();
    chk("run_e1_valid", {31'd0, out_valid}, 32'd0);
    step(); chk_slot("run_e2", 32'h0);
    step(); chk_slot("run_e3", 32'h4);
    step(); chk_slot("run_e4", 32'h8);
    step(); chk_slot("run_e5", 32'hC);

    // Async reset between edges
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    #1 rst_n = 1'b1;
    step();
    chk("arst_e1_valid", {31'd0, out_valid}, 32'd0);
    step(); chk_slot("arst_e2", 32'h0);
    step(); chk_slot("arst_e3", 32'h4);

    // Redirect to 0x40 while out_pc=4 and out_ready=1
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("redir_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    step(); chk_slot("redir_t0", 32'h40);
    step(); chk_slot("redir_t1", 32'h44);
    step(); chk_slot("redir_t2", 32'h48);

    // Stall three cycles with out_pc=0x48
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_slot("stall", 32'h48);
      chk("stall_addr", imem_addr, 32'h4C);
    end
    out_ready = 1'b1;
    step(); chk_slot("resume0", 32'h4C);
    step(); chk_slot("resume1", 32'h50);

    // Wrap around the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_bubble_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk_slot("wrap_top", 32'hFFFF_FFFC);
    chk("wrap_plus4_zero", out_pc_plus4, 32'h0);
    step(); chk_slot("wrap_zero", 32'h0);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis_bubble_valid", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_valid", {31'd0, out_valid}, 32'd0);
      chk("mis_addr", imem_addr, 32'h42);
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("mis_clr_fault", {31'd0, fault}, 32'd0);
    chk("mis_clr_valid", {31'd0, out_valid}, 32'd0);
    chk("mis_clr_addr", imem_addr, 32'h80);
    step(); chk_slot("mis_fetch80", 32'h80);
`else
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_fault", {31'd0, fault}, 32'd0);
    step();
    chk_slot("mis_fetch40", 32'h40);
    chk("mis_fault_after", {31'd0, fault}, 32'd0);
`endif

    // Redirect while stalled flushes the held slot
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_addr", imem_addr, 32'h100);
    step(); chk_slot("flush_fetch", 32'h100);
    out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of `instr_mem`. Holds the program counter, drives the combinational instruction memory address, and registers the returned word with its PC into an output slot handed to decode over a valid/ready handshake. Supports redirect (branch/jump/trap target) with flush, back-pressure stall and optional misaligned-target fault detection.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `XLEN`, 32, address/data width; only 32 is supported
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `imem_addr` out XLEN, byte address to `instr_mem`; equals the PC register
- `imem_instr` in 32, instruction word from `instr_mem`, valid in the same cycle
- `redirect_valid` in 1, load new PC this cycle
- `redirect_pc` in XLEN, redirect target
- `out_valid` out 1, output slot holds a fetched instruction
- `out_ready` in 1, consumer accepts the slot this cycle
- `out_pc` out XLEN, PC of `out_instr`
- `out_pc_plus4` out XLEN, `out_pc + 4`, mod 2^32
- `out_instr` out 32, registered instruction word
- `fault` out 1, misaligned redirect target held (macro-dependent)

## Operation
- States: IDLE, RUN, FAULT.
- IDLE: entered on reset; `out_valid`=0, no fetch; moves to RUN unconditionally on the next edge.
- RUN: if the slot is empty or `out_ready`=1, load `out_pc`←pc, `out_instr`←`imem_instr`, `out_valid`←1, pc←pc+4. Otherwise hold everything.
- Slot drains when `out_ready`=1 and no new load occurs (not reachable in RUN without redirect; relevant for FAULT entry).
- Redirect, any state, highest priority: pc←`redirect_pc`, `out_valid`←0 (flush the slot even when `out_ready`=1), no load that cycle; next state RUN, or FAULT per Configuration.
- FAULT: `fault`=1, `out_valid`=0, pc frozen, no fetch; leaves only on a valid aligned redirect.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- `out_pc_plus4` is computed from `out_pc`, not from pc.

## Timing
- Reset values: pc=`RESET_PC`, `imem_addr`=`RESET_PC`, `out_valid`=0, `out_pc`=0, `out_pc_plus4`=4, `out_instr`=32'h0000_0013 (NOP), `fault`=0, state IDLE.
- First `out_valid`=1 on the second rising edge after `rst_n` deasserts, carrying `RESET_PC`.
- Steady state with `out_ready`=1: one instruction per cycle.
- Redirect asserted in cycle N: `imem_addr`=target in N+1; target instruction valid in N+2; 1-cycle bubble.
- Stall: with `out_valid`=1 and `out_ready`=0, all outputs and pc stable.
- Redirect and `out_ready` in the same cycle: the slot is consumed by the downstream stage and not refilled.
- `rst_n` low mid-operation: all registers clear immediately, without waiting for a clock edge.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with `redirect_pc[1:0]`≠0 enters FAULT, loads pc with the raw target, and raises `fault` from the next cycle until an aligned redirect.
- Undefined: `redirect_pc[1:0]` is forced to 00, FAULT is unreachable, and `fault` is tied to 0.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `NOP_INSTR` (32'h0000_0013), `fetch_state_t` enum {IDLE, RUN, FAULT}.
- One sub-module, `fetch_pc_gen`: combinational next-PC mux (redirect / +4 / hold) plus alignment check. The state machine and the output slot stay in `fetch_unit`.
- The top-level test harness instantiates `fetch_unit` and `instr_mem` together, with `imem_addr` connected to `addr` and `instr` connected to `imem_instr`.

## Test plan
- Reset and run: release reset with `out_ready`=1 and memory words at 0/4/8/12. Edges 2–5 show `out_pc` = 0, 4, 8, 12 with the matching words; no earlier `out_valid`.
- Stall: drop `out_ready` for 3 cycles while `out_pc`=8. `out_pc`=8, `out_instr` and `imem_addr`=12 hold; the stream resumes at 12 with no skip or duplicate.
- Redirect: `redirect_pc`=0x40 while `out_pc`=4 and `out_ready`=1. Next cycle `out_valid`=0; the following cycle `out_pc`=0x40; the word at 8 is never presented.
- Wrap: `redirect_pc`=0xFFFF_FFFC. `out_pc`=0xFFFF_FFFC with `out_pc_plus4`=0, followed by `out_pc`=0.
- Misaligned redirect (macro on): `redirect_pc`=0x42. `fault`=1, `out_valid`=0 held for 5 cycles; redirect 0x80 clears `fault` and fetches 0x80. With the macro off, the same stimulus fetches 0x40.
- Async reset: pulse `rst_n` low mid-stream between edges. Outputs take reset values before the next edge; the restart matches the reset-and-run case.
